mult_share_arbiter: RTL and testbench

//  Shares one iterative multiplier unit (start/ready pulse handshake, operand a*b) among NREQ requesters.

---
 rtl/mult_share_arbiter_pkg.sv | 22 ++
 rtl/mult_share_arbiter_rr_pick.sv | 36 +++
 rtl/mult_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mult_share_arbiter_pkg: shared constants for the multiplier arbiter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package mult_share_arbiter_pkg;

  localparam int W_DEF = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Minimum-1 index width so a single-entry range still yields a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_share_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | mult_share_arbiter_rr_pick: rotate-priority pick after last grant    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mult_share_arbiter_rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   g_o,
  output logic            any_o
);

  // Scan from the farthest offset down so the nearest one after last wins.
  always_comb begin
    int idx;
    idx   = 0;
    g_o   = '0;
    any_o = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (pend_i[idx]) begin
        g_o   = IW'(idx);
        any_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
// +----------------------------------------------------------------------+
// | mult_share_arbiter: round-robin sharing of one iterative multiplier  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_start,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_busy,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      resp_y,
  output logic              resp_err,
  output logic              unit_start,
  output logic [W-1:0]      unit_a,
  output logic [W-1:0]      unit_b,
  input  logic              unit_ready,
  input  logic [W-1:0]      unit_y,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int            IW          = idx_w(NREQ);
  localparam int            CW          = idx_w(TIMEOUT);
  localparam logic [CW-1:0] c_cnt_last  = CW'(TIMEOUT - 1);

  logic [0:0]             state_q, state_d;
  logic [NREQ-1:0]        pend_q, pend_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NREQ-1:0][W-1:0] w_opa, w_opb;
  logic [IW-1:0]          w_pick;
  logic                   w_any, w_grant, w_done_ok, w_done_to, w_overrun;
  logic [NREQ-1:0]        w_accept;

  mult_share_arbiter_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .pend_i (pend_q),
    .last_i (last_q),
    .g_o    (w_pick),
    .any_o  (w_any)
  );

  always_comb begin
    req_busy = pend_q;
    if (state_q == ST_WAIT) req_busy[gnt_q] = 1'b1;
  end

  assign w_accept  = req_start & ~req_busy;
  assign w_overrun = |(req_start & req_busy);
  assign w_grant   = (state_q == ST_IDLE) && w_any;
  assign w_done_ok = (state_q == ST_WAIT) && unit_ready;
  assign w_done_to = (state_q == ST_WAIT) && !unit_ready && (cnt_q == c_cnt_last);

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      logic [W-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (w_accept[i]) begin
          a_q <= req_a[i*W +: W];
          b_q <= req_b[i*W +: W];
        end
      end
      assign w_opa[i] = a_q;
      assign w_opb[i] = b_q;
    end
  endgenerate

  // A picked index is never also being captured: its pend bit holds busy high.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | w_accept;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (w_grant) begin
      pend_d[w_pick] = 1'b0;
      gnt_d          = w_pick;
      cnt_d          = '0;
      state_d        = ST_WAIT;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (w_done_ok || w_done_to) begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      gnt_q       <= '0;
      last_q      <= IW'(NREQ - 1);
      cnt_q       <= '0;
      unit_start  <= 1'b0;
      unit_a      <= '0;
      unit_b      <= '0;
      req_ready   <= '0;
      resp_y      <= '0;
      resp_err    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      unit_start <= w_grant;
      if (w_grant) begin
        unit_a <= w_opa[w_pick];
        unit_b <= w_opb[w_pick];
      end
      req_ready <= '0;
      if (w_done_ok) begin
        resp_y           <= unit_y;
        resp_err         <= 1'b0;
        req_ready[gnt_q] <= 1'b1;
      end else if (w_done_to) begin
        resp_y           <= '0;
        resp_err         <= 1'b1;
        req_ready[gnt_q] <= 1'b1;
        err_timeout      <= 1'b1;
      end
      if (w_overrun) err_overrun <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mult_share_arbiter: directed bench with behavioural multiplier    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mult_share_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_start = '0;
  logic [NREQ*W-1:0] req_a = '0, req_b = '0;
  logic [NREQ-1:0]   req_busy, req_ready;
  logic [W-1:0]      resp_y, unit_a, unit_b;
  logic              resp_err, unit_start, err_overrun, err_timeout;
  logic              unit_ready;
  logic [W-1:0]      unit_y;

  logic [NREQ-1:0]   t_start = '0;
  logic [NREQ*W-1:0] t_a = '0, t_b = '0;
  logic [NREQ-1:0]   t_busy, t_ready;
  logic [W-1:0]      t_y, t_ua, t_ub;
  logic              t_err, t_ustart, t_ovr, t_tmo;
  logic              t_uready = 1'b0;
  logic [W-1:0]      t_uy = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_a(req_a), .req_b(req_b),
    .req_busy(req_busy), .req_ready(req_ready), .resp_y(resp_y), .resp_err(resp_err),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
    .unit_ready(unit_ready), .unit_y(unit_y),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  // Second instance with a short watchdog and a unit that never answers.
  mult_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst), .req_start(t_start), .req_a(t_a), .req_b(t_b),
    .req_busy(t_busy), .req_ready(t_ready), .resp_y(t_y), .resp_err(t_err),
    .unit_start(t_ustart), .unit_a(t_ua), .unit_b(t_ub),
    .unit_ready(t_uready), .unit_y(t_uy),
    .err_overrun(t_ovr), .err_timeout(t_tmo)
  );

  // Multiplier model: ready pulse b+2 cycles after the start pulse is seen.
  initial begin
    int           m_left;
    logic         m_active;
    logic [W-1:0] m_y;
    m_left = 0; m_active = 1'b0; m_y = '0;
    unit_ready = 1'b0; unit_y = '0;
    forever begin
      @(posedge clk); #1;
      unit_ready = 1'b0;
      if (!rst) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          unit_ready = 1'b1;
          unit_y     = m_y;
          m_active   = 1'b0;
        end
      end
      if (rst && unit_start) begin
        m_active = 1'b1;
        m_left   = int'(unit_b) + 2;
        m_y      = unit_a * unit_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_start = '0; t_start = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({req_busy, req_ready, resp_y, resp_err, unit_start, unit_a, unit_b, err_overrun, err_timeout} !== '0)
      $display("FAIL reset_outputs: got busy=%b rdy=%b y=%0d err=%b us=%b a=%0d b=%0d ovr=%b tmo=%b expected all 0",
               req_busy, req_ready, resp_y, resp_err, unit_start, unit_a, unit_b, err_overrun, err_timeout);
    else n_pass++;
    n_checks++;
    if ({t_busy, t_ready, t_y, t_err, t_ustart, t_ua, t_ub, t_ovr, t_tmo} !== '0)
      $display("FAIL reset_outputs_to: got nonzero outputs expected all 0");
    else n_pass++;
  endtask

  task automatic test_single();
    int n, starts;
    req_start = 3'b001; req_a[0 +: W] = 16'd7; req_b[0 +: W] = 16'd5;
    tick(); req_start = '0;
    n_checks++;
    if (req_busy !== 3'b001) $display("FAIL single_busy: got %b expected 001", req_busy); else n_pass++;
    tick();
    n_checks++;
    if ({unit_start, unit_a, unit_b} !== {1'b1, 16'd7, 16'd5})
      $display("FAIL single_unit_start: got us=%b a=%0d b=%0d expected us=1 a=7 b=5", unit_start, unit_a, unit_b);
    else n_pass++;
    n = 0; starts = 0;
    while (req_ready == '0 && n < 100) begin
      tick(); n++;
      if (unit_start) starts++;
    end
    n_checks++;
    if (n != 8) $display("FAIL single_latency: got %0d cycles expected 8", n); else n_pass++;
    n_checks++;
    if (starts != 0) $display("FAIL single_extra_start: got %0d extra starts expected 0", starts); else n_pass++;
    n_checks++;
    if ({req_ready, resp_y, resp_err} !== {3'b001, 16'd35, 1'b0})
      $display("FAIL single_result: got rdy=%b y=%0d err=%b expected rdy=001 y=35 err=0", req_ready, resp_y, resp_err);
    else n_pass++;
    tick();
    n_checks++;
    if ({req_ready, req_busy, resp_y} !== {3'b000, 3'b000, 16'd35})
      $display("FAIL single_after: got rdy=%b busy=%b y=%0d expected rdy=000 busy=000 y=35", req_ready, req_busy, resp_y);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0] exp_rdy [3];
    logic [W-1:0]    exp_y [3];
    int got, n;
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
    exp_y[0] = 16'd12;   exp_y[1] = 16'd12;   exp_y[2] = 16'd27;
    do_reset();
    req_start = 3'b111;
    req_a[0 +: W] = 16'd3; req_b[0 +: W] = 16'd4;
    req_a[W +: W] = 16'd6; req_b[W +: W] = 16'd2;
    req_a[2*W +: W] = 16'd9; req_b[2*W +: W] = 16'd3;
    tick(); req_start = '0;
    got = 0; n = 0;
    while (got < 3 && n < 200) begin
      tick(); n++;
      if (req_ready != '0) begin
        n_checks++;
        if ({req_ready, resp_y, resp_err} !== {exp_rdy[got], exp_y[got], 1'b0})
          $display("FAIL simul_resp%0d: got rdy=%b y=%0d err=%b expected rdy=%b y=%0d err=0",
                   got, req_ready, resp_y, resp_err, exp_rdy[got], exp_y[got]);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 3) $display("FAIL simul_count: got %0d responses expected 3", got); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_rdy [4];
    logic [W-1:0]    exp_y [4];
    int got, n;
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b001; exp_rdy[3] = 3'b010;
    exp_y[0] = 16'd2;    exp_y[1] = 16'd3;    exp_y[2] = 16'd4;    exp_y[3] = 16'd5;
    do_reset();
    req_start = 3'b011;
    req_a[0 +: W] = 16'd2; req_b[0 +: W] = 16'd1;
    req_a[W +: W] = 16'd3; req_b[W +: W] = 16'd1;
    got = 0; n = 0;
    while (got < 4 && n < 400) begin
      tick(); n++;
      req_start = '0;
      if (req_ready != '0) begin
        n_checks++;
        if ({req_ready, resp_y} !== {exp_rdy[got], exp_y[got]})
          $display("FAIL fair_grant%0d: got rdy=%b y=%0d expected rdy=%b y=%0d",
                   got, req_ready, resp_y, exp_rdy[got], exp_y[got]);
        else n_pass++;
        if (got == 0) begin req_start = 3'b001; req_a[0 +: W] = 16'd4; req_b[0 +: W] = 16'd1; end
        if (got == 1) begin req_start = 3'b010; req_a[W +: W] = 16'd5; req_b[W +: W] = 16'd1; end
        got++;
      end
    end
    n_checks++;
    if (got != 4 || err_overrun !== 1'b0)
      $display("FAIL fair_count: got %0d responses ovr=%b expected 4 ovr=0", got, err_overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int pulses;
    do_reset();
    req_start = 3'b010; req_a[W +: W] = 16'd2; req_b[W +: W] = 16'd3;
    tick(); req_start = '0;
    n_checks++;
    if ({req_busy, err_overrun} !== {3'b010, 1'b0})
      $display("FAIL ovr_first: got busy=%b ovr=%b expected busy=010 ovr=0", req_busy, err_overrun);
    else n_pass++;
    tick(); tick();
    req_start = 3'b010; req_a[W +: W] = 16'd9; req_b[W +: W] = 16'd9;
    tick(); req_start = '0;
    n_checks++;
    if (err_overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", err_overrun); else n_pass++;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (req_ready != '0) begin
        pulses++;
        n_checks++;
        if ({req_ready, resp_y} !== {3'b010, 16'd6})
          $display("FAIL ovr_result: got rdy=%b y=%0d expected rdy=010 y=6", req_ready, resp_y);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 1) $display("FAIL ovr_pulses: got %0d expected 1", pulses); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    req_start = 3'b100; req_a[2*W +: W] = 16'd4; req_b[2*W +: W] = 16'd6;
    tick(); req_start = '0;
    tick(); tick(); tick();
    n_checks++;
    if ({req_busy, unit_a, unit_b} !== {3'b100, 16'd4, 16'd6})
      $display("FAIL midrst_pre: got busy=%b a=%0d b=%0d expected busy=100 a=4 b=6", req_busy, unit_a, unit_b);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req_busy, req_ready, resp_y, resp_err, unit_start, unit_a, unit_b, err_overrun, err_timeout} !== '0)
      $display("FAIL midrst_async: got busy=%b rdy=%b y=%0d a=%0d b=%0d ovr=%b expected all 0",
               req_busy, req_ready, resp_y, unit_a, unit_b, err_overrun);
    else n_pass++;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_ready != '0 || unit_start || req_busy != '0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    t_start = 3'b001; t_a[0 +: W] = 16'd3; t_b[0 +: W] = 16'd3;
    tick(); t_start = '0;
    tick();
    n_checks++;
    if ({t_ustart, t_busy, t_tmo} !== {1'b1, 3'b001, 1'b0})
      $display("FAIL to_grant: got us=%b busy=%b tmo=%b expected us=1 busy=001 tmo=0", t_ustart, t_busy, t_tmo);
    else n_pass++;
    n = 0;
    while (t_ready == '0 && n < 50) begin
      tick(); n++;
    end
    n_checks++;
    if (n != 8) $display("FAIL to_latency: got %0d cycles expected 8", n); else n_pass++;
    n_checks++;
    if ({t_ready, t_y, t_err, t_tmo} !== {3'b001, 16'd0, 1'b1, 1'b1})
      $display("FAIL to_result: got rdy=%b y=%0d err=%b tmo=%b expected rdy=001 y=0 err=1 tmo=1",
               t_ready, t_y, t_err, t_tmo);
    else n_pass++;
    tick();
    n_checks++;
    if ({t_ready, t_busy, t_tmo} !== {3'b000, 3'b000, 1'b1})
      $display("FAIL to_after: got rdy=%b busy=%b tmo=%b expected rdy=000 busy=000 tmo=1", t_ready, t_busy, t_tmo);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overrun();
    test_reset_mid_wait();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
